// File: rtl/vga_capture.sv
// VGA timing capture: measures hsync/vsync cadence, locks onto a stable mode and
// strobes active-area pixels with their coordinates and colour.
//
// state   | meaning
// SEARCH  | waiting for a vsync rise to begin a measurement frame
// MEASURE | one frame of line-length consistency checks before trusting the mode
// LOCKED  | mode stable; capturing pixels and watching for timing violations
module vga_capture #(
  parameter int H_START  = 45,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 31,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic [4:0]  red,
  input  logic [4:0]  green,
  input  logic [4:0]  blue,
  input  logic        hsync,
  input  logic        vsync,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [4:0]  pix_red,
  output logic [4:0]  pix_green,
  output logic [4:0]  pix_blue,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] H_LO    = 11'(H_START);
  localparam logic [10:0] H_HI    = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_START);
  localparam logic [10:0] V_HI    = 11'(V_START + V_ACTIVE);
  localparam logic [11:0] V_MIN   = 12'(V_START + V_ACTIVE);

  state_t      state_q, state_d;
  logic        hs_q, vs_q;
  logic        seen_vs_q, seen_vs_d;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [10:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic        sync_err_q, sync_err_d;
  logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [4:0]  pix_red_q, pix_red_d, pix_green_q, pix_green_d, pix_blue_q, pix_blue_d;

  logic        hs_rise, vs_rise, viol, in_win;
  logic [10:0] h_len;
  logic [11:0] v_len;

  always_comb begin
    hs_rise = hsync & ~hs_q;
    vs_rise = vsync & ~vs_q;
    h_len   = h_cnt_q + 11'd1;
    v_len   = {1'b0, v_cnt_q} + 12'd1;

    h_cnt_d = hs_rise ? 11'd0 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 11'd1);
    v_cnt_d = v_cnt_q;
    if (vs_rise)                           v_cnt_d = 11'd0;
    else if (hs_rise && v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 11'd1;

    line_len_d    = hs_rise ? h_len : line_len_q;
    seen_vs_d     = seen_vs_q | vs_rise;
    // The first vsync rise only starts a frame; there is no full frame to measure yet.
    frame_lines_d = (vs_rise && seen_vs_q) ? v_len[10:0] : frame_lines_q;

    state_d = state_q;
    viol    = 1'b0;
    case (state_q)
      SEARCH: if (vs_rise) state_d = MEASURE;
      MEASURE: begin
        if (hs_rise && h_len != line_len_q) state_d = SEARCH;
        else if (vs_rise)                   state_d = (v_len >= V_MIN) ? LOCKED : SEARCH;
      end
      LOCKED: begin
        viol = (hs_rise && h_len != line_len_q) ||
               (vs_rise && v_len != {1'b0, frame_lines_q}) ||
               (h_cnt_q == CNT_MAX);
        if (viol) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase

    in_win = (state_q == LOCKED) && !viol &&
             (h_cnt_q >= H_LO) && (h_cnt_q < H_HI) &&
             (v_cnt_q >= V_LO) && (v_cnt_q < V_HI);

    pix_valid_d   = in_win;
    pix_x_d       = in_win ? h_cnt_q - H_LO : pix_x_q;
    pix_y_d       = in_win ? v_cnt_q - V_LO : pix_y_q;
    pix_red_d     = in_win ? red   : 5'd0;
    pix_green_d   = in_win ? green : 5'd0;
    pix_blue_d    = in_win ? blue  : 5'd0;
    frame_start_d = in_win && (h_cnt_q == H_LO) && (v_cnt_q == V_LO);
    sync_err_d    = viol;
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      seen_vs_q     <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_red_q     <= '0;
      pix_green_q   <= '0;
      pix_blue_q    <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hsync;
      vs_q          <= vsync;
      seen_vs_q     <= seen_vs_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_red_q     <= pix_red_d;
      pix_green_q   <= pix_green_d;
      pix_blue_q    <= pix_blue_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_red     = pix_red_q;
  assign pix_green   = pix_green_q;
  assign pix_blue    = pix_blue_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture using a scaled-down video mode
// (20 clocks/line, 12 lines/frame, 8x6 active area).
module tb_vga_capture;

  localparam int LINE   = 20;
  localparam int HS_LOW = 3;
  localparam int NLINES = 12;
  localparam int H_ST   = 4;
  localparam int H_ACT  = 8;
  localparam int V_ST   = 2;
  localparam int V_ACT  = 6;
  localparam int ALL    = 99;

  logic        clk_25 = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  red = '0, green = '0, blue = '0;
  logic        hsync = 1'b1, vsync = 1'b1;
  logic        pix_valid, frame_start, locked, sync_err;
  logic [10:0] pix_x, pix_y, line_len, frame_lines;
  logic [4:0]  pix_red, pix_green, pix_blue;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [4:0]  r;
    logic [4:0]  g;
    logic [4:0]  b;
  } px_t;

  px_t sb[$];
  int  n_cmp = 0, n_err = 0;
  int  err_cnt = 0, fs_cnt = 0;
  bit  have_last = 0, prev_full = 0;
  logic [10:0] last_x = '0, last_y = '0;

  vga_capture #(.H_START(H_ST), .H_ACTIVE(H_ACT), .V_START(V_ST), .V_ACTIVE(V_ACT)) dut (
    .clk_25(clk_25), .rst(rst),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
    .line_len(line_len), .frame_lines(frame_lines)
  );

  always #20 clk_25 = ~clk_25;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_25) begin
    if (pix_valid) begin
      if (sb.size() == 0) check("unexpected_px", pix_valid, 1'b0);
      else begin
        px_t e;
        e = sb.pop_front();
        check("pix", {pix_x, pix_y, pix_red, pix_green, pix_blue}, e);
      end
      if (frame_start) begin
        fs_cnt++;
        check("fs_pos", {pix_x, pix_y}, 22'd0);
        if (have_last) check("last_px", {last_x, last_y}, {11'(H_ACT - 1), 11'(V_ACT - 1)});
      end
      last_x    = pix_x;
      last_y    = pix_y;
      have_last = 1;
    end else begin
      check("idle_out", {frame_start, pix_red, pix_green, pix_blue}, 16'd0);
    end
    if (sync_err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  // Line timing: hsync high from position 0 (the rise), low for the last HS_LOW clocks.
  // vsync is low for the whole last line so its rise coincides with the hsync rise of line 0.
  task automatic gen_frame(input int nlines, input int px_limit, input int odd_line,
                           input int odd_len, input int rst_line, input int exp_err,
                           input bit exp_lock);
    int  exp_fs, len, xi;
    bit  after_rst, do_rst;
    px_t e;
    exp_fs = 0; after_rst = 0; err_cnt = 0; fs_cnt = 0;
    if (!prev_full) have_last = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == odd_line) ? odd_len : LINE;
      for (int p = 0; p < len; p++) begin
        xi     = p - H_ST - 1;
        hsync  = (p < len - HS_LOW);
        vsync  = (l != nlines - 1);
        red    = xi[4:0];
        green  = l[4:0];
        blue   = 5'($urandom_range(0, 31));
        do_rst = (l == rst_line) && (p == 8);
        rst    = do_rst;
        if (!do_rst && !after_rst && l < px_limit && l >= V_ST && l < V_ST + V_ACT &&
            xi >= 0 && xi < H_ACT) begin
          e.x = 11'(xi); e.y = 11'(l - V_ST); e.r = red; e.g = green; e.b = blue;
          sb.push_back(e);
          if (xi == 0 && l == V_ST) exp_fs++;
        end
        tick();
        if (do_rst) begin
          rst = 1'b0;
          after_rst = 1;
          check("rst_outputs", {pix_valid, locked, sync_err, frame_start, pix_x, pix_y,
                                pix_red, pix_green, pix_blue, line_len, frame_lines}, 64'd0);
        end
        if (len > 2048 && p == 2047) check("hsat_early", sync_err, 1'b0);
        if (len > 2048 && p == 2048) check("hsat_err", {sync_err, locked}, 2'b10);
      end
    end
    check("locked", locked, exp_lock);
    check("sb_drained", sb.size(), 0);
    check("sync_err_pulses", err_cnt, exp_err);
    check("frame_starts", fs_cnt, exp_fs);
    prev_full = (px_limit == ALL) && (odd_line < 0) && (rst_line < 0);
  endtask

  task automatic do_reset();
    hsync = 1'b1; vsync = 1'b1; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    prev_full = 0;
  endtask

  initial begin
    do_reset();
    check("rst_locked", locked, 1'b0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    check("rst_line_len", line_len, 11'd0);
    check("rst_frame_lines", frame_lines, 11'd0);
    check("rst_pix_xy", {pix_x, pix_y}, 22'd0);

    // Too few lines per frame: must never lock.
    repeat (4) gen_frame(6, 0, -1, 0, -1, 0, 1'b0);

    do_reset();
    gen_frame(NLINES, 0, -1, 0, -1, 0, 1'b0);
    gen_frame(NLINES, 0, -1, 0, -1, 0, 1'b0);
    check("frame_lines_first", frame_lines, 11'd0);
    gen_frame(NLINES, ALL, -1, 0, -1, 0, 1'b1);
    check("line_len", line_len, 11'(LINE));
    check("frame_lines", frame_lines, 11'(NLINES));
    gen_frame(NLINES, ALL, -1, 0, -1, 0, 1'b1);

    // One line one clock short: violation at the next hsync rise (line 6).
    gen_frame(NLINES, 6, 5, LINE - 1, -1, 1, 1'b0);
    gen_frame(NLINES, 0, -1, 0, -1, 0, 1'b0);
    gen_frame(NLINES, ALL, -1, 0, -1, 0, 1'b1);
    gen_frame(NLINES, ALL, -1, 0, -1, 0, 1'b1);

    // hsync stuck high for 3000 clocks: h_cnt saturates.
    gen_frame(NLINES, ALL, 9, 3000 + HS_LOW, -1, 1, 1'b0);
    gen_frame(NLINES, 0, -1, 0, -1, 0, 1'b0);
    gen_frame(NLINES, ALL, -1, 0, -1, 0, 1'b1);
    check("frame_lines_relock", frame_lines, 11'(NLINES));

    // One-cycle reset mid active area while locked.
    gen_frame(NLINES, ALL, -1, 0, 4, 0, 1'b0);
    gen_frame(NLINES, 0, -1, 0, -1, 0, 1'b0);
    gen_frame(NLINES, ALL, -1, 0, -1, 0, 1'b1);
    gen_frame(NLINES, ALL, -1, 0, -1, 0, 1'b1);
    check("line_len_end", line_len, 11'(LINE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
